interrupt_controller: RTL



---
 rtl/interrupt_controller.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Prioritised interrupt controller sitting between the CTC timer/counter
// outputs (plus other peripheral sources) and the CPU's single interrupt
// input. Source events are latched into a pending register. A software mask
// is applied, and a fixed priority picks the winner (source 0 highest). One
// request with its source ID goes to the CPU. In-service state is tracked
// with nesting until the CPU writes an EOI.
//
// Ports:
//   clock          system clock, all logic on posedge
//   reset          asynchronous, active-high reset
//   irq_n          active-low interrupt sources (bit0=CTC0, bit1=CTC1)
//   intCtrl        chip select for register access
//   read_enable    register read strobe (wins over write_enable)
//   write_enable   register write strobe
//   address        register select: 0 pending/W1C, 2 mask, 4 in-service,
//                  6 status/EOI
//   write_data_in  write data from CPU
//   read_data_out  registered read data, holds until the next read
//   int_req        interrupt request to CPU, active-high
//   int_id         index of the requested source, valid while int_req=1
//   int_ack        one-cycle CPU acknowledge of the presented request
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int                 N_SRC     = 6,
    parameter logic [N_SRC-1:0]   EDGE_MASK = 6'b000011
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_n,
    input  logic              intCtrl,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [2:0]        address,
    input  logic [15:0]       write_data_in,
    output logic [15:0]       read_data_out,
    output logic              int_req,
    output logic [2:0]        int_id,
    input  logic              int_ack
);

    localparam logic [2:0] ADDR_PEND   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_INSERV = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Index of the lowest set bit (the highest-priority source); 0 if none.
    function automatic logic [2:0] f_lowest_idx(input logic [N_SRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot of the lowest set bit; all zero if none.
    function automatic logic [N_SRC-1:0] f_lowest_onehot(input logic [N_SRC-1:0] v);
        logic [N_SRC-1:0] oh;
        logic             seen;
        oh   = {N_SRC{1'b0}};
        seen = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            oh[i] = v[i] & ~seen;
            seen  = seen | v[i];
        end
        return oh;
    endfunction

    // Nesting window: bit i is 1 when no in-service bit exists at index <= i,
    // i.e. only sources of strictly higher priority than the active one.
    function automatic logic [N_SRC-1:0] f_prio_window(input logic [N_SRC-1:0] isv);
        logic [N_SRC-1:0] win;
        logic             seen;
        win  = {N_SRC{1'b0}};
        seen = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            seen   = seen | isv[i];
            win[i] = ~seen;
        end
        return win;
    endfunction

    // Zero-extend a source vector onto the 16-bit data bus.
    function automatic logic [15:0] f_ext(input logic [N_SRC-1:0] v);
        logic [15:0] r;
        r             = 16'h0000;
        r[N_SRC-1:0]  = v;
        return r;
    endfunction

    state_t             r_state;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_in_service;
    logic [N_SRC-1:0]   r_irq_hist;
    logic               r_int_req;
    logic [2:0]         r_int_id;
    logic [15:0]        r_read_data;

    state_t             w_next_state;
    logic               w_next_req;
    logic [2:0]         w_next_id;
    logic               w_ack;
    logic               w_rd_en;
    logic               w_wr_en;
    logic [N_SRC-1:0]   w_event;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_w1c;
    logic [N_SRC-1:0]   w_ack_onehot;
    logic [N_SRC-1:0]   w_eoi_clr;
    logic [N_SRC-1:0]   w_pending_next;
    logic [N_SRC-1:0]   w_in_service_next;
    logic               w_unused;

    assign w_unused = ^write_data_in[15:N_SRC];

    assign read_data_out = r_read_data;
    assign int_req       = r_int_req;
    assign int_id        = r_int_id;

    // Bus decode, event detection, eligibility and next pending/in-service.
    always_comb begin
        w_rd_en = intCtrl & read_enable;
        w_wr_en = intCtrl & write_enable & ~read_enable;

        // Edge sources: previous sample 1, current 0. Level sources: low now.
        w_event    = (EDGE_MASK & r_irq_hist & ~irq_n) | (~EDGE_MASK & ~irq_n);
        w_eligible = r_pending & r_mask & f_prio_window(r_in_service);

        if (w_wr_en && (address == ADDR_PEND)) begin
            w_w1c = write_data_in[N_SRC-1:0];
        end else begin
            w_w1c = {N_SRC{1'b0}};
        end

        if (w_wr_en && (address == ADDR_STATUS)) begin
            w_eoi_clr = f_lowest_onehot(r_in_service);
        end else begin
            w_eoi_clr = {N_SRC{1'b0}};
        end

        for (int i = 0; i < N_SRC; i++) begin
            w_ack_onehot[i] = w_ack & (r_int_id == 3'(i));
        end

        // A new event beats a same-cycle ack clear or W1C on that bit.
        w_pending_next    = (r_pending & ~w_w1c & ~w_ack_onehot) | w_event;
        // EOI removes the active level before the ack adds the new one.
        w_in_service_next = (r_in_service & ~w_eoi_clr) | w_ack_onehot;
    end

    // Request FSM next-state and next registered outputs.
    always_comb begin
        w_next_state = r_state;
        w_next_req   = 1'b0;
        w_next_id    = r_int_id;
        w_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eligible != {N_SRC{1'b0}}) begin
                    w_next_state = ST_REQ;
                    w_next_req   = 1'b1;
                    w_next_id    = f_lowest_idx(w_eligible);
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    // Ack applies to the ID the CPU was shown this cycle.
                    w_ack        = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_eligible != {N_SRC{1'b0}}) begin
                    w_next_state = ST_REQ;
                    w_next_req   = 1'b1;
                    w_next_id    = f_lowest_idx(w_eligible);
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register and registered request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_int_req <= 1'b0;
            r_int_id  <= 3'd0;
        end else begin
            r_state   <= w_next_state;
            r_int_req <= w_next_req;
            r_int_id  <= w_next_id;
        end
    end

    // Pending, mask, in-service and source history registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending    <= {N_SRC{1'b0}};
            r_mask       <= {N_SRC{1'b0}};
            r_in_service <= {N_SRC{1'b0}};
            r_irq_hist   <= {N_SRC{1'b1}};
        end else begin
            r_pending    <= w_pending_next;
            r_in_service <= w_in_service_next;
            r_irq_hist   <= irq_n;
            if (w_wr_en && (address == ADDR_MASK)) begin
                r_mask <= write_data_in[N_SRC-1:0];
            end else begin
                r_mask <= r_mask;
            end
        end
    end

    // Registered read data, captured on the read strobe and held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_read_data <= 16'h0000;
        end else if (w_rd_en) begin
            case (address)
                ADDR_PEND:   r_read_data <= f_ext(r_pending);
                ADDR_MASK:   r_read_data <= f_ext(r_mask);
                ADDR_INSERV: r_read_data <= f_ext(r_in_service);
                ADDR_STATUS: r_read_data <= {r_int_req, 12'h000, r_int_id};
                default:     r_read_data <= 16'h0000;
            endcase
        end else begin
            r_read_data <= r_read_data;
        end
    end

endmodule
